frame_access_sequencer: RTL and testbench
=========================================

# frame_access_sequencer

Single-clock controller that sequences the shared camera-frame SDRAM buffer between the three users: camera capture (write FIFOs), HPS pixel readout and VGA display (read FIFOs). It replaces ad-hoc muxing of write-clock gating, read-request source and read-clock source with one state machine. It also issues the FIFO address-reload pulses and reports frame/pixel progress to the HPS PIO bank. It sits between CCD_Capture/RAW2RGB, the HPS PIO exports, VGA_Controller and Sdram_Control_4Port.

## Interface
- FRAME_PIXELS, 307200: pixels per frame (640*480); HPS readout length.
- CAP_FRAMES, 1: frames written per capture request, 1..15.
- TIMEOUT_CYC, 50000000: cycles allowed in CAP_ARM waiting for frame start.
- LOAD_CYC, 4: width of oLOAD pulse in cycles, 1..15.
- iCLK  in  1  system clock (CLOCK_50 domain); all inputs synchronous to it.
- iRST  in  1  synchronous, active-high reset.
- iCAP_REQ  in  1  capture request pulse (KEY or HPS start PIO, already edge-detected).
- iHPS_REQ  in  1  level; HPS wants a full-frame readout.
- iHPS_STEP  in  1  one-cycle pulse per pixel the HPS consumes.
- iVGA_REQ  in  1  VGA pixel read request.
- iFVAL  in  1  camera frame-valid, already synchronized to iCLK.
- oWR_EN  out  1  write-FIFO enable (gates write clock/WR1/WR2).
- oRD_REQ  out  1  read strobe to RD1/RD2.
- oRD_SEL  out  1  read source: 0 = VGA, 1 = HPS.
- oLOAD  out  1  address reload to all FIFO LOAD inputs.
- oBUSY  out  1  high in any state other than DISPLAY.
- oSTATE  out  2  current state encoding.
- oPIX_CNT  out  19  HPS pixels read in current readout.
- oFRAME_DONE  out  1  one-cycle pulse on capture or readout completion.
- oERR  out  1  sticky capture-timeout flag.

## Operation
- States: DISPLAY=0, CAP_ARM=1, CAP_RUN=2, HPS_READ=3. Reset state is DISPLAY.
- Reset values: oWR_EN=0, oRD_SEL=0, oLOAD=0, oBUSY=0, oSTATE=0, oPIX_CNT=0, oFRAME_DONE=0, oERR=0.
- Internal reset values: frame count 0, timeout count 0, fval_d 0.
- fval_d registers iFVAL every cycle. rise = iFVAL & ~fval_d; fall = ~iFVAL & fval_d.
- DISPLAY
  - oRD_SEL=0; oRD_REQ = iVGA_REQ.
  - iCAP_REQ goes to CAP_ARM. It has priority over iHPS_REQ when both are present in the same cycle.
  - Otherwise iHPS_REQ=1 goes to HPS_READ.
- CAP_ARM
  - Entry clears oERR, frame count and timeout count, and fires oLOAD.
  - oRD_REQ=0.
  - rise goes to CAP_RUN. Entering while iFVAL is already high waits for the next frame; a partial frame is never written.
  - If the timeout count reaches TIMEOUT_CYC-1 with no rise: go to DISPLAY, set oERR, fire oLOAD.
- CAP_RUN
  - oWR_EN = iFVAL.
  - On each fall, frame count increments.
  - When the increment reaches CAP_FRAMES: go to DISPLAY, pulse oFRAME_DONE, fire oLOAD.
  - Before that count is reached, the state stays CAP_RUN and oWR_EN re-asserts on the next frame.
- HPS_READ
  - Entry clears oPIX_CNT and fires oLOAD.
  - oRD_SEL=1; oRD_REQ = iHPS_STEP & ~oLOAD; steps that arrive during oLOAD are dropped and not counted.
  - Each accepted step increments oPIX_CNT.
  - The accepted step that makes oPIX_CNT == FRAME_PIXELS goes to DISPLAY, pulses oFRAME_DONE and fires oLOAD. oPIX_CNT holds its final value until the next HPS_READ entry.
  - iHPS_REQ deasserting mid-readout aborts to DISPLAY with oLOAD and no oFRAME_DONE.
- Request handling outside DISPLAY
  - iCAP_REQ is ignored in CAP_ARM, CAP_RUN and HPS_READ.
  - iHPS_REQ is a level and is honoured on return to DISPLAY; this is one cycle of DISPLAY minimum.
- oLOAD: registered pulse of exactly LOAD_CYC cycles, starting the cycle after the transition. A new fire during an active pulse restarts the count.
- oBUSY = (state != DISPLAY). oSTATE = state.
- Counter widths: 19-bit pixel count, no wrap (terminal at FRAME_PIXELS). 4-bit frame count. 26-bit timeout count.

## Timing
- Registered outputs, reflecting the state after the transition edge: state, oSTATE, oBUSY, oLOAD, oFRAME_DONE, oERR, oPIX_CNT.
- Combinational from registered state: oWR_EN, oRD_REQ, oRD_SEL. They have 0-cycle latency from iFVAL/iVGA_REQ/iHPS_STEP, so VGA pixel alignment is preserved.
- Input to state change: 1 cycle from iCAP_REQ/iHPS_REQ/rise/fall.
- oWR_EN rises in the same cycle iFVAL is high after entering CAP_RUN, i.e. the cycle after rise.
- iRST mid-operation: next cycle is DISPLAY with all outputs at reset values. No oLOAD is issued; the SDRAM controller has its own reset reload.

## Test plan
- Capture, simple case: reset, iCAP_REQ pulse, iFVAL low 10 cycles then high 100 then low.
  - oLOAD is high 4 cycles after entry.
  - oWR_EN is high for exactly 99 cycles (first FVAL cycle is consumed by edge detect).
  - oFRAME_DONE pulses once; state returns to 0.
- Mid-frame arm: iCAP_REQ while iFVAL already high.
  - No oWR_EN until iFVAL falls and rises again.
  - With CAP_FRAMES=2, two full frames are written before oFRAME_DONE.
- Capture timeout: TIMEOUT_CYC=20, iFVAL held low.
  - State returns to DISPLAY after 20 cycles in CAP_ARM; oERR=1.
  - The next iCAP_REQ clears oERR.
- HPS readout: FRAME_PIXELS=8, iHPS_REQ high, a step every other cycle including during oLOAD.
  - Steps inside oLOAD are dropped.
  - oPIX_CNT ends at 8, oFRAME_DONE pulses, oRD_SEL returns to 0.
- Priority and abort:
  - iCAP_REQ and iHPS_REQ in the same cycle enters CAP_ARM; HPS_READ follows one cycle after capture completes.
  - Dropping iHPS_REQ at oPIX_CNT=3 returns to DISPLAY with no oFRAME_DONE.
- Reset mid-capture: iRST during CAP_RUN with iFVAL high.
  - Next cycle oWR_EN=0, oSTATE=0, oLOAD=0, oPIX_CNT=0.

Source files
------------

// File: rtl/frame_access_sequencer.sv
// frame_access_sequencer: arbitrates the shared camera-frame SDRAM buffer between
// camera capture, HPS pixel readout and VGA display, and drives the FIFO reloads.
`default_nettype none

module frame_access_sequencer #(
  parameter int FRAME_PIXELS = 307200,
  parameter int CAP_FRAMES   = 1,
  parameter int TIMEOUT_CYC  = 50000000,
  parameter int LOAD_CYC     = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iCAP_REQ,
  input  logic        iHPS_REQ,
  input  logic        iHPS_STEP,
  input  logic        iVGA_REQ,
  input  logic        iFVAL,
  output logic        oWR_EN,
  output logic        oRD_REQ,
  output logic        oRD_SEL,
  output logic        oLOAD,
  output logic        oBUSY,
  output logic [1:0]  oSTATE,
  output logic [18:0] oPIX_CNT,
  output logic        oFRAME_DONE,
  output logic        oERR
);

  localparam logic [1:0]  c_st_display  = 2'd0;
  localparam logic [1:0]  c_st_cap_arm  = 2'd1;
  localparam logic [1:0]  c_st_cap_run  = 2'd2;
  localparam logic [1:0]  c_st_hps_read = 2'd3;

  localparam logic [18:0] c_frame_pixels = 19'(FRAME_PIXELS);
  localparam logic [3:0]  c_cap_frames   = 4'(CAP_FRAMES);
  localparam logic [25:0] c_timeout_last = 26'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  c_load_cyc     = 4'(LOAD_CYC);

  logic [1:0]  state_q, state_d;
  logic        fval_q;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic [25:0] to_cnt_q, to_cnt_d;
  logic [18:0] pix_cnt_q, pix_cnt_d;
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic        load_q;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        w_load_fire;

  logic        w_rise, w_fall, w_step_ok;
  logic [3:0]  w_frame_next;
  logic [18:0] w_pix_next;

  assign w_rise       = iFVAL & ~fval_q;
  assign w_fall       = ~iFVAL & fval_q;
  assign w_step_ok    = iHPS_STEP & ~load_q;
  assign w_frame_next = frame_cnt_q + 4'd1;
  assign w_pix_next   = pix_cnt_q + 19'd1;

  // State and counter registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= c_st_display;
      fval_q      <= 1'b0;
      frame_cnt_q <= 4'd0;
      to_cnt_q    <= 26'd0;
      pix_cnt_q   <= 19'd0;
      load_cnt_q  <= 4'd0;
      load_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_q      <= iFVAL;
      frame_cnt_q <= frame_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      load_cnt_q  <= load_cnt_d;
      load_q      <= (load_cnt_d != 4'd0);
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    to_cnt_d    = to_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    w_load_fire = 1'b0;
    case (state_q)
      c_st_display: begin
        if (iCAP_REQ) begin
          state_d     = c_st_cap_arm;
          err_d       = 1'b0;
          frame_cnt_d = 4'd0;
          to_cnt_d    = 26'd0;
          w_load_fire = 1'b1;
        end else if (iHPS_REQ) begin
          state_d     = c_st_hps_read;
          pix_cnt_d   = 19'd0;
          w_load_fire = 1'b1;
        end
      end
      c_st_cap_arm: begin
        if (w_rise) begin
          state_d = c_st_cap_run;
        end else if (to_cnt_q == c_timeout_last) begin
          state_d     = c_st_display;
          err_d       = 1'b1;
          w_load_fire = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 26'd1;
        end
      end
      c_st_cap_run: begin
        if (w_fall) begin
          frame_cnt_d = w_frame_next;
          if (w_frame_next == c_cap_frames) begin
            state_d     = c_st_display;
            done_d      = 1'b1;
            w_load_fire = 1'b1;
          end
        end
      end
      c_st_hps_read: begin
        // A completing step wins over a simultaneous request drop.
        if (w_step_ok) pix_cnt_d = w_pix_next;
        if (w_step_ok && (w_pix_next == c_frame_pixels)) begin
          state_d     = c_st_display;
          done_d      = 1'b1;
          w_load_fire = 1'b1;
        end else if (!iHPS_REQ) begin
          state_d     = c_st_display;
          w_load_fire = 1'b1;
        end
      end
      default: state_d = c_st_display;
    endcase

    // A fire during an active pulse restarts the full width.
    if (w_load_fire)              load_cnt_d = c_load_cyc;
    else if (load_cnt_q != 4'd0)  load_cnt_d = load_cnt_q - 4'd1;
    else                          load_cnt_d = 4'd0;
  end

  // Datapath steering, combinational so pixel alignment is kept
  always_comb begin
    oWR_EN  = 1'b0;
    oRD_REQ = 1'b0;
    oRD_SEL = 1'b0;
    case (state_q)
      c_st_display:  oRD_REQ = iVGA_REQ;
      c_st_cap_run:  oWR_EN  = iFVAL;
      c_st_hps_read: begin
        oRD_SEL = 1'b1;
        oRD_REQ = w_step_ok;
      end
      default: ;
    endcase
  end

  assign oLOAD       = load_q;
  assign oBUSY       = (state_q != c_st_display);
  assign oSTATE      = state_q;
  assign oPIX_CNT    = pix_cnt_q;
  assign oFRAME_DONE = done_q;
  assign oERR        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_access_sequencer.sv
// Directed bench for frame_access_sequencer (small frame, timeout and capture-count parameters).
`default_nettype none

module tb_frame_access_sequencer;

  logic        iCLK = 1'b0;
  logic        iRST, iCAP_REQ, iHPS_REQ, iHPS_STEP, iVGA_REQ, iFVAL;
  logic        oWR_EN, oRD_REQ, oRD_SEL, oLOAD, oBUSY, oFRAME_DONE, oERR;
  logic [1:0]  oSTATE;
  logic [18:0] oPIX_CNT;

  int checks = 0;
  int failures = 0;
  int wr_cnt, load_cnt, rdreq_cnt, done_cnt, sel_cnt, n;

  frame_access_sequencer #(
    .FRAME_PIXELS(8),
    .CAP_FRAMES  (2),
    .TIMEOUT_CYC (20),
    .LOAD_CYC    (4)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iCAP_REQ   (iCAP_REQ),
    .iHPS_REQ   (iHPS_REQ),
    .iHPS_STEP  (iHPS_STEP),
    .iVGA_REQ   (iVGA_REQ),
    .iFVAL      (iFVAL),
    .oWR_EN     (oWR_EN),
    .oRD_REQ    (oRD_REQ),
    .oRD_SEL    (oRD_SEL),
    .oLOAD      (oLOAD),
    .oBUSY      (oBUSY),
    .oSTATE     (oSTATE),
    .oPIX_CNT   (oPIX_CNT),
    .oFRAME_DONE(oFRAME_DONE),
    .oERR       (oERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    wr_cnt = 0; load_cnt = 0; rdreq_cnt = 0; done_cnt = 0;
  endtask

  // Hold iFVAL at val for n cycles, tallying outputs in each cycle.
  task automatic run(input logic val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      iFVAL = val;
      #1;
      if (oWR_EN)      wr_cnt++;
      if (oLOAD)       load_cnt++;
      if (oRD_REQ)     rdreq_cnt++;
      if (oFRAME_DONE) done_cnt++;
      cyc();
    end
  endtask

  task automatic wait_arm_exit();
    n = 0;
    while (oSTATE == 2'd1 && n < 100) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    iRST = 1'b1; iCAP_REQ = 1'b0; iHPS_REQ = 1'b0; iHPS_STEP = 1'b0;
    iVGA_REQ = 1'b0; iFVAL = 1'b0;
    cyc(); cyc();
    iRST = 1'b0;

    // Reset state
    chk("rst_state", 32'(oSTATE), 32'd0);
    chk("rst_busy",  32'(oBUSY), 32'd0);
    chk("rst_load",  32'(oLOAD), 32'd0);
    chk("rst_wren",  32'(oWR_EN), 32'd0);
    chk("rst_sel",   32'(oRD_SEL), 32'd0);
    chk("rst_pix",   32'(oPIX_CNT), 32'd0);
    chk("rst_done",  32'(oFRAME_DONE), 32'd0);
    chk("rst_err",   32'(oERR), 32'd0);
    iVGA_REQ = 1'b1;
    #1;
    chk("vga_rdreq", 32'(oRD_REQ), 32'd1);

    // Two-frame capture from a clean arm
    iCAP_REQ = 1'b1;
    cyc();
    iCAP_REQ = 1'b0;
    chk("arm_state", 32'(oSTATE), 32'd1);
    chk("arm_busy",  32'(oBUSY), 32'd1);
    clr_counts();
    run(1'b0, 10); run(1'b1, 100); run(1'b0, 10); run(1'b1, 100); run(1'b0, 1);
    chk("cap_load_cycles", 32'(load_cnt), 32'd4);
    chk("cap_wr_cycles",   32'(wr_cnt), 32'd199);
    chk("cap_no_rdreq",    32'(rdreq_cnt), 32'd0);
    chk("cap_early_done",  32'(done_cnt), 32'd0);
    chk("cap_end_state",   32'(oSTATE), 32'd0);
    chk("cap_done",        32'(oFRAME_DONE), 32'd1);
    chk("cap_end_load",    32'(oLOAD), 32'd1);
    chk("cap_vga_back",    32'(oRD_REQ), 32'd1);
    cyc();
    chk("cap_done_pulse",  32'(oFRAME_DONE), 32'd0);
    iVGA_REQ = 1'b0;
    run(1'b0, 5);

    // Arm while a frame is already in progress
    run(1'b1, 3);
    iCAP_REQ = 1'b1;
    cyc();
    iCAP_REQ = 1'b0;
    clr_counts();
    run(1'b1, 5);
    chk("mid_no_wr",    32'(wr_cnt), 32'd0);
    chk("mid_state",    32'(oSTATE), 32'd1);
    run(1'b0, 5); run(1'b1, 50); run(1'b0, 5); run(1'b1, 50); run(1'b0, 1);
    chk("mid_wr_cycles", 32'(wr_cnt), 32'd99);
    chk("mid_early_done", 32'(done_cnt), 32'd0);
    chk("mid_end_state", 32'(oSTATE), 32'd0);
    chk("mid_done",      32'(oFRAME_DONE), 32'd1);
    run(1'b0, 5);

    // Capture timeout
    iCAP_REQ = 1'b1;
    cyc();
    iCAP_REQ = 1'b0;
    wait_arm_exit();
    chk("to_arm_cycles", 32'(n), 32'd20);
    chk("to_state",      32'(oSTATE), 32'd0);
    chk("to_err",        32'(oERR), 32'd1);
    chk("to_load",       32'(oLOAD), 32'd1);
    chk("to_no_done",    32'(oFRAME_DONE), 32'd0);
    run(1'b0, 5);
    chk("to_err_sticky", 32'(oERR), 32'd1);
    iCAP_REQ = 1'b1;
    cyc();
    iCAP_REQ = 1'b0;
    chk("rearm_err_clr", 32'(oERR), 32'd0);
    wait_arm_exit();
    chk("to2_arm_cycles", 32'(n), 32'd20);
    run(1'b0, 5);

    // Simultaneous capture and HPS request, then HPS readout
    iHPS_REQ = 1'b1;
    iCAP_REQ = 1'b1;
    cyc();
    iCAP_REQ = 1'b0;
    chk("prio_state", 32'(oSTATE), 32'd1);
    chk("prio_err_clr", 32'(oERR), 32'd0);
    run(1'b0, 3); run(1'b1, 10); run(1'b0, 3); run(1'b1, 10); run(1'b0, 1);
    chk("prio_cap_end", 32'(oSTATE), 32'd0);
    chk("prio_cap_done", 32'(oFRAME_DONE), 32'd1);
    cyc();
    chk("hps_state", 32'(oSTATE), 32'd3);
    chk("hps_sel",   32'(oRD_SEL), 32'd1);
    chk("hps_load",  32'(oLOAD), 32'd1);
    chk("hps_pix0",  32'(oPIX_CNT), 32'd0);
    n = 0; rdreq_cnt = 0; sel_cnt = 0;
    while (oSTATE == 2'd3 && n < 100) begin
      iHPS_STEP = (n % 2 == 0);
      #1;
      if (oRD_REQ) rdreq_cnt++;
      if (oRD_SEL) sel_cnt++;
      n++;
      cyc();
    end
    iHPS_STEP = 1'b0;
    chk("hps_cycles",  32'(n), 32'd19);
    chk("hps_rdreqs",  32'(rdreq_cnt), 32'd8);
    chk("hps_sel_cyc", 32'(sel_cnt), 32'd19);
    chk("hps_end_state", 32'(oSTATE), 32'd0);
    chk("hps_pix_end", 32'(oPIX_CNT), 32'd8);
    chk("hps_done",    32'(oFRAME_DONE), 32'd1);
    chk("hps_sel_back", 32'(oRD_SEL), 32'd0);
    chk("hps_end_load", 32'(oLOAD), 32'd1);

    // Level request re-enters; abort at three pixels
    cyc();
    chk("ab_state", 32'(oSTATE), 32'd3);
    chk("ab_pix_clr", 32'(oPIX_CNT), 32'd0);
    cyc(); cyc(); cyc(); cyc();
    chk("ab_load_off", 32'(oLOAD), 32'd0);
    iHPS_STEP = 1'b1;
    cyc(); cyc(); cyc();
    iHPS_STEP = 1'b0;
    iHPS_REQ = 1'b0;
    #1;
    chk("ab_pix3", 32'(oPIX_CNT), 32'd3);
    cyc();
    chk("ab_end_state", 32'(oSTATE), 32'd0);
    chk("ab_no_done", 32'(oFRAME_DONE), 32'd0);
    chk("ab_load", 32'(oLOAD), 32'd1);
    chk("ab_pix_hold", 32'(oPIX_CNT), 32'd3);

    // Reset in the middle of a capture
    run(1'b0, 5);
    iCAP_REQ = 1'b1;
    cyc();
    iCAP_REQ = 1'b0;
    iFVAL = 1'b1;
    cyc();
    iCAP_REQ = 1'b1;
    #1;
    chk("run_wren", 32'(oWR_EN), 32'd1);
    cyc();
    iCAP_REQ = 1'b0;
    chk("run_ignore_cap", 32'(oSTATE), 32'd2);
    chk("run_load", 32'(oLOAD), 32'd1);
    iRST = 1'b1;
    cyc();
    iRST = 1'b0;
    #1;
    chk("mrst_wren",  32'(oWR_EN), 32'd0);
    chk("mrst_state", 32'(oSTATE), 32'd0);
    chk("mrst_load",  32'(oLOAD), 32'd0);
    chk("mrst_pix",   32'(oPIX_CNT), 32'd0);
    iFVAL = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
